axis_rr_arbiter: RTL

//   N:1 round-robin arbiter for AXI Stream; merges NUM_SRC producers onto one stream.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_if.sv | 15 +
 rtl/axis_rr_arbiter_prio_enc.sv | 41 ++++
 rtl/axis_rr_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Package: axis_pkg
// Shared source-id type and the round-robin pointer wrap helper used by
// axis_rr_arbiter. The source-id type is sized for the largest supported
// source count; each arbiter narrows it to its own SRC_W.
package axis_pkg;

  // Widest source index an arbiter instance may use (up to 256 sources).
  localparam int unsigned SRC_ID_MAX_W = 8;

  typedef logic [SRC_ID_MAX_W-1:0] axis_src_id_t;

  // Advance a round-robin pointer by one, wrapping explicitly at num_src-1 so
  // non-power-of-two source counts never produce an out-of-range index.
  function automatic axis_src_id_t rr_next(input axis_src_id_t cur,
                                           input int unsigned  num_src);
    if (cur >= axis_src_id_t'(num_src - 1)) begin
      return '0;
    end
    return cur + axis_src_id_t'(1);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Interface: axis_if
// Minimal AXI Stream bundle (tvalid/tready/tdata). The manager modport drives
// valid and data; the subordinate modport drives ready.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/axis_rr_arbiter_prio_enc.sv
// Module: rr_prio_enc
// Combinational rotating priority encoder. Scans requests starting at the
// pointer and wrapping modulo NUM_SRC; the first active request wins.
module rr_prio_enc #(
  parameter  int NUM_SRC = 2,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [SRC_W-1:0]   o_gnt,
  output logic               o_gnt_vld
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = SRC_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [SRC_W-1:0] w_idx;

  // Pick the first requester at or after the pointer, in rotating order.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path that
    // never assigns it would make synthesis infer a latch.
    o_gnt     = '0;
    o_gnt_vld = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_SRC)) begin
        w_sum = w_sum - SUM_W'(NUM_SRC);
      end
      w_idx = w_sum[SRC_W-1:0];
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt     = w_idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Module: axis_rr_arbiter
// N:1 round-robin AXI Stream arbiter with a registered one-entry output slice,
// so axis_mif.tvalid/tdata never depend combinationally on the inputs.
// The granted source becomes lowest priority for the next grant.
// Optional feature macro: AXIS_RR_ARB_SRC_ID_EN adds the m_src_id output.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  axis_if.s                axis_sif [NUM_SRC],
  axis_if.m                axis_mif,
  input  logic             invalidate
`ifdef AXIS_RR_ARB_SRC_ID_EN
  ,
  output logic [SRC_W-1:0] m_src_id
`endif
);

  localparam int TDATA_WIDTH = $bits(axis_mif.tdata);

  if (NUM_SRC < 2 || NUM_SRC > (1 << SRC_ID_MAX_W)) begin : g_num_src_err
    $fatal(1, "axis_rr_arbiter: NUM_SRC out of supported range");
  end

  logic                   r_tvalid;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [SRC_W-1:0]       r_ptr;
`ifdef AXIS_RR_ARB_SRC_ID_EN
  logic [SRC_W-1:0]       r_src;
`endif

  logic [NUM_SRC-1:0]     w_req;
  logic [TDATA_WIDTH-1:0] w_tdata [NUM_SRC];
  logic [SRC_W-1:0]       w_gnt;
  logic                   w_gnt_vld;
  logic                   w_load;
  logic                   w_hs;
  logic [SRC_W-1:0]       w_ptr_nxt;

  // Slot is free, or its beat leaves this cycle; invalidate blocks any accept.
  assign w_load    = !r_tvalid || axis_mif.tready;
  assign w_hs      = w_load && w_gnt_vld && !invalidate;
  assign w_ptr_nxt = SRC_W'(rr_next(axis_src_id_t'(w_gnt), NUM_SRC));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    if ($bits(axis_sif[g].tdata) != TDATA_WIDTH) begin : g_width_err
      $fatal(1, "axis_rr_arbiter: axis_sif TDATA width differs from axis_mif");
    end
    assign w_req[g]           = axis_sif[g].tvalid;
    assign w_tdata[g]         = axis_sif[g].tdata;
    // Only the granted source sees tready, so at most one handshake per cycle.
    assign axis_sif[g].tready = w_hs && (w_gnt == SRC_W'(g));
  end

  rr_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld)
  );

  // Output slice and round-robin pointer; invalidate outranks a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_ptr    <= '0;
    end else if (invalidate) begin
      r_tvalid <= 1'b0;
    end else if (w_hs) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_tvalid <= 1'b1;
      r_tdata  <= w_tdata[w_gnt];
      r_ptr    <= w_ptr_nxt;
    end else if (axis_mif.tready) begin
      r_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_RR_ARB_SRC_ID_EN
  // Source id of the beat held in the output slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src <= '0;
    end else if (w_hs) begin
      r_src <= w_gnt;
    end
  end

  assign m_src_id = r_src;
`endif

  assign axis_mif.tvalid = r_tvalid;
  assign axis_mif.tdata  = r_tdata;

endmodule
